// File: rtl/wb_pkg.sv
// rtl/wb_pkg.sv - shared constants for the writeback port arbiter
// Purpose: default widths, grant index encodings and the hardwired-zero register index.
// Ports: none (package).
package wb_pkg;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int CNT_W  = 16;

  // Grant index encodings; also the value driven on the data mux select.
  localparam logic GRANT_REQ0 = 1'b0;
  localparam logic GRANT_REQ1 = 1'b1;

  // GR0 reads as zero, so writes to it are consumed but never issued.
  localparam logic [ADDR_W-1:0] GR0_ADDR = '0;

endpackage

// File: rtl/wb_port_arbiter_if.sv
// rtl/wb_port_arbiter_if.sv - bus bundle between writeback requesters and the arbiter
// Purpose: groups the two request channels, stall, mux select, RF write port and counter.
// Ports (signals):
//   req0_valid/addr/data, req0_ready : ALU writeback channel
//   req1_valid/addr/data, req1_ready : load writeback channel
//   wb_stall                         : RF port unavailable
//   mux_sel                          : writeback data mux select
//   rf_we/rf_waddr/rf_wdata          : registered RF write
//   conflict_cnt                     : saturating conflict counter
// Modports: master (requester/bench side), slave (arbiter side).
interface wb_port_arbiter_if #(
  parameter int DATA_W = wb_pkg::DATA_W,
  parameter int ADDR_W = wb_pkg::ADDR_W,
  parameter int CNT_W  = wb_pkg::CNT_W
);

  logic              req0_valid;
  logic [ADDR_W-1:0] req0_addr;
  logic [DATA_W-1:0] req0_data;
  logic              req0_ready;

  logic              req1_valid;
  logic [ADDR_W-1:0] req1_addr;
  logic [DATA_W-1:0] req1_data;
  logic              req1_ready;

  logic              wb_stall;
  logic              mux_sel;

  logic              rf_we;
  logic [ADDR_W-1:0] rf_waddr;
  logic [DATA_W-1:0] rf_wdata;
  logic [CNT_W-1:0]  conflict_cnt;

  modport master (
    output req0_valid, req0_addr, req0_data,
    output req1_valid, req1_addr, req1_data,
    output wb_stall,
    input  req0_ready, req1_ready, mux_sel,
    input  rf_we, rf_waddr, rf_wdata, conflict_cnt
  );

  modport slave (
    input  req0_valid, req0_addr, req0_data,
    input  req1_valid, req1_addr, req1_data,
    input  wb_stall,
    output req0_ready, req1_ready, mux_sel,
    output rf_we, rf_waddr, rf_wdata, conflict_cnt
  );

endinterface

// File: rtl/MUX2x1_32bits.sv
// rtl/MUX2x1_32bits.sv - 2:1 writeback data multiplexer
// Purpose: selects between the two writeback data words.
// Ports: A (S=0 input), B (S=1 input), S (select), Y (output).
module MUX2x1_32bits #(
  parameter int W = 32
) (
  input  logic [W-1:0] A,
  input  logic [W-1:0] B,
  input  logic         S,
  output logic [W-1:0] Y
);

  assign Y = S ? B : A;

endmodule

// File: rtl/wb_port_arbiter.sv
// rtl/wb_port_arbiter.sv - round-robin arbiter for the single register-file write port
// Purpose: grants ALU (req0) or load (req1) writebacks with valid/ready, drives the data
//   mux select, registers the winning write one cycle later and counts conflicts.
// Ports:
//   clk   : rising-edge clock
//   rst_n : synchronous reset, active-low
//   bus   : wb_port_arbiter_if.slave (request channels, stall, mux_sel, RF write, counter)
module wb_port_arbiter #(
  parameter int DATA_W = wb_pkg::DATA_W,
  parameter int ADDR_W = wb_pkg::ADDR_W,
  parameter int CNT_W  = wb_pkg::CNT_W
) (
  input  logic                 clk,
  input  logic                 rst_n,
  wb_port_arbiter_if.slave     bus
);

  import wb_pkg::*;

  logic              last_grant_q, last_grant_d;
  logic              rf_we_q, rf_we_d;
  logic [ADDR_W-1:0] rf_waddr_q, rf_waddr_d;
  logic [DATA_W-1:0] rf_wdata_q, rf_wdata_d;
  logic [CNT_W-1:0]  conflict_cnt_q, conflict_cnt_d;

  logic              grant_ok;
  logic              gnt0, gnt1;
  logic              xfer;
  logic              sel;
  logic [ADDR_W-1:0] gnt_addr;
  logic [DATA_W-1:0] gnt_data;

  // Grants are also suppressed while reset is asserted so no request is consumed
  // by a cycle whose write is going to be discarded.
  always_comb begin
    grant_ok = rst_n && !bus.wb_stall;
    gnt0     = grant_ok && bus.req0_valid && (!bus.req1_valid || last_grant_q == GRANT_REQ1);
    gnt1     = grant_ok && bus.req1_valid && (!bus.req0_valid || last_grant_q == GRANT_REQ0);
    xfer     = gnt0 || gnt1;
    sel      = gnt1 ? GRANT_REQ1 : GRANT_REQ0;
    gnt_addr = (sel == GRANT_REQ1) ? bus.req1_addr : bus.req0_addr;
  end

  MUX2x1_32bits #(
    .W (DATA_W)
  ) u_data_mux (
    .A (bus.req0_data),
    .B (bus.req1_data),
    .S (sel),
    .Y (gnt_data)
  );

  always_comb begin
    last_grant_d   = last_grant_q;
    rf_we_d        = 1'b0;
    rf_waddr_d     = rf_waddr_q;
    rf_wdata_d     = rf_wdata_q;
    conflict_cnt_d = conflict_cnt_q;

    if (xfer) begin
      last_grant_d = sel;
      rf_we_d      = (gnt_addr != ADDR_W'(GR0_ADDR));
      rf_waddr_d   = gnt_addr;
      rf_wdata_d   = gnt_data;
    end

    if (bus.req0_valid && bus.req1_valid && !bus.wb_stall &&
        conflict_cnt_q != {CNT_W{1'b1}}) begin
      conflict_cnt_d = conflict_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      last_grant_q   <= GRANT_REQ1;
      rf_we_q        <= 1'b0;
      rf_waddr_q     <= '0;
      rf_wdata_q     <= '0;
      conflict_cnt_q <= '0;
    end else begin
      last_grant_q   <= last_grant_d;
      rf_we_q        <= rf_we_d;
      rf_waddr_q     <= rf_waddr_d;
      rf_wdata_q     <= rf_wdata_d;
      conflict_cnt_q <= conflict_cnt_d;
    end
  end

  assign bus.req0_ready   = gnt0;
  assign bus.req1_ready   = gnt1;
  assign bus.mux_sel      = sel;
  assign bus.rf_we        = rf_we_q;
  assign bus.rf_waddr     = rf_waddr_q;
  assign bus.rf_wdata     = rf_wdata_q;
  assign bus.conflict_cnt = conflict_cnt_q;

endmodule

// File: tb/tb_wb_port_arbiter.sv
// tb/tb_wb_port_arbiter.sv - directed self-checking bench for wb_port_arbiter
module tb_wb_port_arbiter;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  wb_port_arbiter_if bus ();

  wb_port_arbiter dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v0, input logic [4:0] a0, input logic [31:0] d0,
                       input logic v1, input logic [4:0] a1, input logic [31:0] d1,
                       input logic stall);
    bus.req0_valid = v0;
    bus.req0_addr  = a0;
    bus.req0_data  = d0;
    bus.req1_valid = v1;
    bus.req1_addr  = a1;
    bus.req1_data  = d1;
    bus.wb_stall   = stall;
  endtask

  // Inputs change and combinational outputs are sampled away from the rising edge;
  // registered outputs are sampled 1 time unit after it.
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0);
    next_cycle();

    // 1. Reset with both requesters valid
    drive(1'b1, 5'd3, 32'h3333_3333, 1'b1, 5'd7, 32'h7777_7777, 1'b0);
    #1;
    chk("rst_ready0", {63'd0, bus.req0_ready}, 64'd0);
    chk("rst_ready1", {63'd0, bus.req1_ready}, 64'd0);
    next_cycle();
    chk("rst_we",    {63'd0, bus.rf_we}, 64'd0);
    chk("rst_waddr", {59'd0, bus.rf_waddr}, 64'd0);
    chk("rst_wdata", {32'd0, bus.rf_wdata}, 64'd0);
    chk("rst_cnt",   {48'd0, bus.conflict_cnt}, 64'd0);
    rst_n = 1'b1;
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0);
    #1;
    chk("idle_ready0", {63'd0, bus.req0_ready}, 64'd0);
    chk("idle_mux",    {63'd0, bus.mux_sel}, 64'd0);
    next_cycle();
    chk("idle_we", {63'd0, bus.rf_we}, 64'd0);

    // 2. Single requester, back-to-back
    drive(1'b1, 5'd5, 32'hDEAD_BEEF, 1'b0, 5'd0, 32'h0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("single_ready0", {63'd0, bus.req0_ready}, 64'd1);
      chk("single_ready1", {63'd0, bus.req1_ready}, 64'd0);
      chk("single_mux",    {63'd0, bus.mux_sel}, 64'd0);
      next_cycle();
      chk("single_we",    {63'd0, bus.rf_we}, 64'd1);
      chk("single_waddr", {59'd0, bus.rf_waddr}, 64'd5);
      chk("single_wdata", {32'd0, bus.rf_wdata}, 64'hDEAD_BEEF);
    end
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0);
    next_cycle();
    chk("single_end_we",    {63'd0, bus.rf_we}, 64'd0);
    chk("single_hold_addr", {59'd0, bus.rf_waddr}, 64'd5);
    chk("single_hold_data", {32'd0, bus.rf_wdata}, 64'hDEAD_BEEF);

    // 3. Conflict round-robin starting from reset state (req0 wins first)
    rst_n = 1'b0;
    next_cycle();
    rst_n = 1'b1;
    drive(1'b1, 5'd3, 32'h3333_3333, 1'b1, 5'd7, 32'h7777_7777, 1'b0);
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("rr_ready0", {63'd0, bus.req0_ready}, (i % 2 == 0) ? 64'd1 : 64'd0);
      chk("rr_ready1", {63'd0, bus.req1_ready}, (i % 2 == 1) ? 64'd1 : 64'd0);
      chk("rr_mux",    {63'd0, bus.mux_sel},    (i % 2 == 1) ? 64'd1 : 64'd0);
      next_cycle();
      chk("rr_we",    {63'd0, bus.rf_we}, 64'd1);
      chk("rr_waddr", {59'd0, bus.rf_waddr}, (i % 2 == 1) ? 64'd7 : 64'd3);
      chk("rr_wdata", {32'd0, bus.rf_wdata}, (i % 2 == 1) ? 64'h7777_7777 : 64'h3333_3333);
    end
    chk("rr_cnt", {48'd0, bus.conflict_cnt}, 64'd4);

    // 4. Stall for 3 cycles with both valid; last grant was req1
    drive(1'b1, 5'd3, 32'h3333_3333, 1'b1, 5'd7, 32'h7777_7777, 1'b1);
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("stall_ready0", {63'd0, bus.req0_ready}, 64'd0);
      chk("stall_ready1", {63'd0, bus.req1_ready}, 64'd0);
      chk("stall_mux",    {63'd0, bus.mux_sel}, 64'd0);
      next_cycle();
      chk("stall_we",  {63'd0, bus.rf_we}, 64'd0);
      chk("stall_cnt", {48'd0, bus.conflict_cnt}, 64'd4);
    end
    bus.wb_stall = 1'b0;
    #1;
    chk("unstall_ready0", {63'd0, bus.req0_ready}, 64'd1);
    chk("unstall_ready1", {63'd0, bus.req1_ready}, 64'd0);
    next_cycle();
    chk("unstall_we",    {63'd0, bus.rf_we}, 64'd1);
    chk("unstall_waddr", {59'd0, bus.rf_waddr}, 64'd3);
    chk("unstall_cnt",   {48'd0, bus.conflict_cnt}, 64'd5);

    // 5. Write to GR0 is consumed but not issued
    drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 32'h1234_5678, 1'b0);
    #1;
    chk("gr0_ready1", {63'd0, bus.req1_ready}, 64'd1);
    chk("gr0_mux",    {63'd0, bus.mux_sel}, 64'd1);
    next_cycle();
    chk("gr0_we",    {63'd0, bus.rf_we}, 64'd0);
    chk("gr0_wdata", {32'd0, bus.rf_wdata}, 64'h1234_5678);

    // 6a. Counter saturation: preload 0xFFFE, then three conflict cycles
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0);
    force dut.conflict_cnt_d = 16'hFFFE;
    next_cycle();
    release dut.conflict_cnt_d;
    chk("sat_preload", {48'd0, bus.conflict_cnt}, 64'hFFFE);
    drive(1'b1, 5'd1, 32'h1111_1111, 1'b1, 5'd2, 32'h2222_2222, 1'b0);
    for (int i = 0; i < 3; i++) begin
      next_cycle();
      chk("sat_cnt", {48'd0, bus.conflict_cnt}, 64'hFFFF);
    end

    // 6b. Reset mid-operation: grant, then reset while a request is pending
    drive(1'b1, 5'd9, 32'hAAAA_5555, 1'b0, 5'd0, 32'h0, 1'b0);
    next_cycle();
    chk("mid_we_before", {63'd0, bus.rf_we}, 64'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_ready0", {63'd0, bus.req0_ready}, 64'd0);
    next_cycle();
    chk("mid_we",    {63'd0, bus.rf_we}, 64'd0);
    chk("mid_waddr", {59'd0, bus.rf_waddr}, 64'd0);
    chk("mid_cnt",   {48'd0, bus.conflict_cnt}, 64'd0);
    rst_n = 1'b1;
    drive(1'b1, 5'd4, 32'h4444_4444, 1'b1, 5'd4, 32'h5555_5555, 1'b0);
    #1;
    chk("post_rst_ready0", {63'd0, bus.req0_ready}, 64'd1);
    next_cycle();
    chk("post_rst_wdata", {32'd0, bus.rf_wdata}, 64'h4444_4444);
    #1;
    chk("same_addr_ready1", {63'd0, bus.req1_ready}, 64'd1);
    next_cycle();
    chk("same_addr_we",    {63'd0, bus.rf_we}, 64'd1);
    chk("same_addr_wdata", {32'd0, bus.rf_wdata}, 64'h5555_5555);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
